baud_ctrl: RTL and testbench

Configuration and sequencing controller for the UART baud generator. It stages host divisor writes (DLL, DLM, PSD) while DLAB is set. It commits them atomically only once in-flight TX/RX characters have drained, then pulses new_baud. It grants baud_tick/sample_tick enables to the TX and RX engines only while the generator reports active.

---
 rtl/baud_ctrl_if.sv | 43 ++++
 rtl/baud_ctrl.sv | 155 +++++++++++++++
 tb/tb_baud_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/baud_ctrl_if.sv
// Host configuration, engine handshake and baud generator signals of the baud controller.
interface baud_ctrl_if #(
   parameter int unsigned DL_WIDTH  = 16,
   parameter int unsigned PSD_WIDTH = 4
);
   // Host register access
   logic                 dlab;
   logic                 cfg_wr;
   logic [1:0]           cfg_sel;
   logic [7:0]           cfg_wdata;
   // TX/RX engine handshake
   logic                 tx_req;
   logic                 rx_req;
   logic                 tx_busy;
   logic                 rx_busy;
   // Baud generator
   logic                 active;
   logic [DL_WIDTH-1:0]  divisor_latch;
   logic [PSD_WIDTH-1:0] psd;
   logic                 new_baud;
   // Grants and status
   logic                 enable_baud;
   logic                 enable_sample;
   logic                 cfg_pending;
   logic                 cfg_busy;
   logic                 cfg_err;

   // Environment side: host, engines and generator
   modport master (
      output dlab, cfg_wr, cfg_sel, cfg_wdata,
      output tx_req, rx_req, tx_busy, rx_busy, active,
      input  divisor_latch, psd, new_baud,
      input  enable_baud, enable_sample, cfg_pending, cfg_busy, cfg_err
   );

   // Controller side
   modport slave (
      input  dlab, cfg_wr, cfg_sel, cfg_wdata,
      input  tx_req, rx_req, tx_busy, rx_busy, active,
      output divisor_latch, psd, new_baud,
      output enable_baud, enable_sample, cfg_pending, cfg_busy, cfg_err
   );
endinterface

// File: rtl/baud_ctrl.sv
// Baud configuration controller: stages divisor writes, commits them once TX/RX
// characters have drained, requests a generator recompute and gates tick enables.
module baud_ctrl #(
   parameter int unsigned DL_WIDTH    = 16,
   parameter int unsigned PSD_WIDTH   = 4,
   parameter int unsigned ACT_TIMEOUT = 64
) (
   input logic        clk,
   input logic        reset,
   baud_ctrl_if.slave bus
);

   localparam int unsigned CNT_W    = $clog2(ACT_TIMEOUT + 1);
   localparam int unsigned CNT_LAST = ACT_TIMEOUT - 1;

   localparam logic [1:0] SEL_DLL = 2'd0;
   localparam logic [1:0] SEL_DLM = 2'd1;
   localparam logic [1:0] SEL_PSD = 2'd2;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_DRAIN,
      ST_LOAD,
      ST_SETTLE,
      ST_WAIT_ACT
   } state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [DL_WIDTH-1:0]  dl_stg_q;
   logic [PSD_WIDTH-1:0] psd_stg_q;
   logic [DL_WIDTH-1:0]  dl_q;
   logic [PSD_WIDTH-1:0] psd_q;
   logic                 pend_q;
   logic                 new_baud_q;
   logic                 en_baud_q;
   logic                 en_sample_q;
   logic                 busy_q;
   logic                 err_q;

   logic                 stage_wr;
   logic                 grant_ok;
   logic                 drained;

   // A host write only counts while the divisor latch is open and the target is real.
   assign stage_wr = bus.cfg_wr && bus.dlab && (bus.cfg_sel != 2'd3);
   // Ticks may flow only while the old divisors are still in force.
   assign grant_ok = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   // Safe point to swap divisors: nothing in flight and the host has closed the latch.
   assign drained  = !bus.tx_busy && !bus.rx_busy && !bus.dlab;

   // Staged divisor bytes, writable in every state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dl_stg_q  <= DL_WIDTH'(1);
         psd_stg_q <= '0;
      end else if (stage_wr) begin
         case (bus.cfg_sel)
            SEL_DLL: dl_stg_q[7:0]  <= bus.cfg_wdata;
            SEL_DLM: dl_stg_q[15:8] <= bus.cfg_wdata;
            SEL_PSD: psd_stg_q      <= bus.cfg_wdata[PSD_WIDTH-1:0];
            default: ;
         endcase
      end
   end

   // Pending flag: set by any staging write, cleared as LOAD retires unless refreshed then.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= 1'b0;
      end else if (stage_wr) begin
         pend_q <= 1'b1;
      end else if (state_q == ST_LOAD) begin
         pend_q <= 1'b0;
      end
   end

   // Tick grants follow requests one cycle late, and only with a live generator.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_baud_q   <= 1'b0;
         en_sample_q <= 1'b0;
      end else begin
         en_baud_q   <= grant_ok && bus.tx_req && bus.active;
         en_sample_q <= grant_ok && bus.rx_req && bus.active;
      end
   end

   // Commit sequencer: drain, load divisors, let the generator settle, wait for active.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_SETTLE;
         cnt_q      <= '0;
         dl_q       <= DL_WIDTH'(1);
         psd_q      <= '0;
         new_baud_q <= 1'b0;
         busy_q     <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         new_baud_q <= 1'b0;
         case (state_q)
            ST_RUN: begin
               if (pend_q && !bus.dlab) begin
                  state_q <= ST_DRAIN;
                  busy_q  <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (drained) begin
                  state_q    <= ST_LOAD;
                  dl_q       <= dl_stg_q;
                  psd_q      <= psd_stg_q;
                  new_baud_q <= 1'b1;
               end
            end
            ST_LOAD: begin
               state_q <= ST_SETTLE;
            end
            ST_SETTLE: begin
               // active may still describe the old divisors here, so it is not looked at.
               cnt_q   <= '0;
               state_q <= ST_WAIT_ACT;
            end
            ST_WAIT_ACT: begin
               if (bus.active) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b0;
               end else if (cnt_q == CNT_W'(CNT_LAST)) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_SETTLE;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   // Output drive
   assign bus.divisor_latch = dl_q;
   assign bus.psd           = psd_q;
   assign bus.new_baud      = new_baud_q;
   assign bus.enable_baud   = en_baud_q;
   assign bus.enable_sample = en_sample_q;
   assign bus.cfg_pending   = pend_q;
   assign bus.cfg_busy      = busy_q;
   assign bus.cfg_err       = err_q;

endmodule

// File: tb/tb_baud_ctrl.sv
// Self-checking bench for baud_ctrl: directed commit scenarios plus a random phase,
// compared every cycle against a behavioural model of the commit protocol.
module tb_baud_ctrl;

   localparam int unsigned DLW = 16;
   localparam int unsigned PSW = 4;
   localparam int unsigned TO  = 64;

   // Model phases of the commit protocol
   localparam int P_IDLE  = 0;
   localparam int P_DRAIN = 1;
   localparam int P_LOAD  = 2;
   localparam int P_GRACE = 3;
   localparam int P_WAIT  = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   baud_ctrl_if #(.DL_WIDTH(DLW), .PSD_WIDTH(PSW)) bif();

   baud_ctrl #(.DL_WIDTH(DLW), .PSD_WIDTH(PSW), .ACT_TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model state
   logic [15:0] m_stg;
   logic [3:0]  m_psd_stg;
   logic [15:0] m_dl;
   logic [3:0]  m_psd;
   logic        m_pend, m_err, m_nb, m_eb, m_es;
   int          m_phase;
   int          m_cyc;
   int          m_wait_start;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_stg = 16'h0001; m_psd_stg = 4'h0;
      m_dl  = 16'h0001; m_psd     = 4'h0;
      m_pend = 1'b0; m_err = 1'b0; m_nb = 1'b0; m_eb = 1'b0; m_es = 1'b0;
      m_phase = P_GRACE;
   endtask

   // One clock of the protocol, from the inputs presented during the cycle.
   task automatic model_clock();
      logic wr;
      logic can_tick;
      int   ph;
      m_cyc++;
      ph = m_phase;
      wr = bif.cfg_wr && bif.dlab && (bif.cfg_sel != 2'd3);
      can_tick = (ph == P_IDLE) || (ph == P_DRAIN);
      m_eb = can_tick && bif.tx_req && bif.active;
      m_es = can_tick && bif.rx_req && bif.active;
      m_nb = 1'b0;
      case (ph)
         P_IDLE:  if (m_pend && !bif.dlab) m_phase = P_DRAIN;
         P_DRAIN: if (!bif.tx_busy && !bif.rx_busy && !bif.dlab) begin
                     m_dl = m_stg; m_psd = m_psd_stg; m_nb = 1'b1; m_phase = P_LOAD;
                  end
         P_LOAD:  m_phase = P_GRACE;
         P_GRACE: begin m_phase = P_WAIT; m_wait_start = m_cyc + 1; end
         default: begin
                     if (bif.active) begin m_phase = P_IDLE; m_err = 1'b0; end
                     else if (m_cyc - m_wait_start == TO - 1) begin
                        m_phase = P_IDLE; m_err = 1'b1;
                     end
                  end
      endcase
      if (wr) begin
         if (bif.cfg_sel == 2'd0) m_stg[7:0] = bif.cfg_wdata;
         else if (bif.cfg_sel == 2'd1) m_stg[15:8] = bif.cfg_wdata;
         else m_psd_stg = bif.cfg_wdata[3:0];
         m_pend = 1'b1;
      end else if (ph == P_LOAD) begin
         m_pend = 1'b0;
      end
   endtask

   task automatic check_all();
      chk("divisor_latch", 32'(bif.divisor_latch), 32'(m_dl));
      chk("psd",           32'(bif.psd),           32'(m_psd));
      chk("new_baud",      32'(bif.new_baud),      32'(m_nb));
      chk("enable_baud",   32'(bif.enable_baud),   32'(m_eb));
      chk("enable_sample", 32'(bif.enable_sample), 32'(m_es));
      chk("cfg_pending",   32'(bif.cfg_pending),   32'(m_pend));
      chk("cfg_busy",      32'(bif.cfg_busy),      32'(m_phase != P_IDLE));
      chk("cfg_err",       32'(bif.cfg_err),       32'(m_err));
   endtask

   // Advance one clock; inputs change only after the falling edge check.
   task automatic tick();
      @(posedge clk);
      model_clock();
      @(negedge clk);
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic stage(input logic [1:0] sel, input logic [7:0] data);
      bif.dlab = 1'b1; bif.cfg_wr = 1'b1; bif.cfg_sel = sel; bif.cfg_wdata = data;
      tick();
      bif.cfg_wr = 1'b0;
   endtask

   task automatic wait_phase(input int ph, input int budget, input string tag);
      logic found;
      found = (m_phase == ph);
      for (int i = 0; i < budget && !found; i++) begin
         tick();
         found = (m_phase == ph);
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   logic [7:0] r8;

   initial begin
      m_cyc = 0; m_wait_start = 0;
      bif.dlab = 1'b0; bif.cfg_wr = 1'b0; bif.cfg_sel = 2'd0; bif.cfg_wdata = 8'h00;
      bif.tx_req = 1'b1; bif.rx_req = 1'b1; bif.tx_busy = 1'b0; bif.rx_busy = 1'b0;
      bif.active = 1'b0;
      reset = 1'b0;
      #1 reset = 1'b1;
      model_reset();
      #2 check_all();
      @(negedge clk);
      reset = 1'b0;

      // Power-up: grants wait for the generator to report active
      for (int i = 0; i < 10; i++) begin
         if (i == 5) bif.active = 1'b1;
         tick();
      end
      chk("pwr_enable_baud", 32'(bif.enable_baud), 32'd1);
      chk("pwr_busy", 32'(bif.cfg_busy), 32'd0);

      // Basic commit of DL=0x000C, PSD=3 with a late active
      stage(2'd0, 8'h0C);
      stage(2'd1, 8'h00);
      stage(2'd2, 8'h03);
      bif.dlab = 1'b0;
      wait_phase(P_LOAD, 3, "reach_load");
      chk("dl_commit", 32'(bif.divisor_latch), 32'h000C);
      chk("psd_commit", 32'(bif.psd), 32'd3);
      bif.active = 1'b0;
      ticks(4);
      bif.active = 1'b1;
      ticks(4);

      // Commit held off by a long TX character
      r8 = 8'($urandom);
      stage(2'd0, r8);
      bif.dlab = 1'b0; bif.tx_busy = 1'b1;
      ticks(40);
      chk("dl_hold", 32'(bif.divisor_latch), 32'h000C);
      chk("en_during_drain", 32'(bif.enable_baud), 32'd1);
      bif.tx_busy = 1'b0;
      wait_phase(P_LOAD, 3, "reach_load_after_tx");
      chk("dl_after_tx", 32'(bif.divisor_latch), 32'({8'h00, r8}));
      ticks(6);

      // Write with the latch closed is ignored
      bif.dlab = 1'b0; bif.cfg_wr = 1'b1; bif.cfg_sel = 2'd0; bif.cfg_wdata = 8'hFF;
      tick();
      bif.cfg_wr = 1'b0;
      ticks(3);
      chk("closed_wr_pending", 32'(bif.cfg_pending), 32'd0);

      // Generator never becomes active: timeout flags the error
      stage(2'd2, 8'($urandom));
      bif.dlab = 1'b0; bif.active = 1'b0;
      wait_phase(P_WAIT, 6, "reach_wait");
      ticks(TO + 2);
      chk("timeout_err", 32'(bif.cfg_err), 32'd1);
      chk("timeout_run", 32'(bif.cfg_busy), 32'd0);
      bif.active = 1'b1;
      stage(2'd1, 8'($urandom));
      bif.dlab = 1'b0;
      ticks(8);
      chk("err_cleared", 32'(bif.cfg_err), 32'd0);

      // Staging write landing in the LOAD cycle keeps a second commit pending
      stage(2'd0, 8'($urandom));
      bif.dlab = 1'b0;
      wait_phase(P_LOAD, 4, "reach_load_2");
      r8 = 8'($urandom);
      bif.dlab = 1'b1; bif.cfg_wr = 1'b1; bif.cfg_sel = 2'd0; bif.cfg_wdata = r8;
      tick();
      bif.cfg_wr = 1'b0; bif.dlab = 1'b0;
      chk("load_wr_pending", 32'(bif.cfg_pending), 32'd1);
      wait_phase(P_LOAD, 10, "second_commit");
      chk("second_dl_low", 32'(bif.divisor_latch[7:0]), 32'(r8));
      ticks(4);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) bif.dlab = ~bif.dlab;
         bif.cfg_wr    = ($urandom_range(0, 2) == 0);
         bif.cfg_sel   = 2'($urandom);
         bif.cfg_wdata = 8'($urandom);
         bif.tx_req    = 1'($urandom);
         bif.rx_req    = 1'($urandom);
         bif.tx_busy   = ($urandom_range(0, 3) == 0);
         bif.rx_busy   = ($urandom_range(0, 3) == 0);
         bif.active    = ($urandom_range(0, 9) != 0);
         tick();
      end
      bif.cfg_wr = 1'b0; bif.dlab = 1'b0; bif.tx_busy = 1'b0; bif.rx_busy = 1'b0;
      bif.active = 1'b1;
      ticks(8);

      // Asynchronous reset in the middle of WAIT_ACT
      stage(2'd0, 8'($urandom));
      bif.dlab = 1'b0; bif.active = 1'b0;
      wait_phase(P_WAIT, 6, "reach_wait_rst");
      ticks(2);
      #2 reset = 1'b1;
      model_reset();
      #1 check_all();
      @(negedge clk);
      reset = 1'b0;
      bif.active = 1'b1;
      ticks(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
